// File: rtl/csi2tx_pkt_if_arbiter_pkg.sv
// ============================================================================
// Module      : csi2tx_pkt_if_arbiter_pkg
// Description : Shared arbiter constants and saturating byte arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package csi2tx_pkt_if_arbiter_pkg;

    localparam logic [1:0] ARB_IDLE = 2'b00;
    localparam logic [1:0] ARB_HDR  = 2'b01;
    localparam logic [1:0] ARB_DATA = 2'b10;

    localparam logic [5:0] DT_FS        = 6'h00;
    localparam logic [5:0] DT_FE        = 6'h01;
    localparam logic [5:0] SHORT_DT_MAX = 6'h0F;

    localparam logic [15:0] HDR_PAYLOAD_BYTES = 16'd4;
    localparam logic [15:0] BEAT_BYTES        = 16'd8;

    // a - min(a, b): remaining-byte counts never wrap below zero
    function automatic logic [15:0] sat_sub(input logic [15:0] a, input logic [15:0] b);
        return (a > b) ? (a - b) : 16'd0;
    endfunction

endpackage

`default_nettype wire

// File: rtl/csi2tx_pkt_if_arbiter_if.sv
// ============================================================================
// Module      : csi2tx_pkt_if_arbiter_if
// Description : Packet header + 64-bit payload handshake bundle, N lanes wide.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface csi2tx_pkt_if_arbiter_if #(
    parameter int N = 1
) ();

    logic [N-1:0]      packet_valid;
    logic [6*N-1:0]    packet_dt;
    logic [2*N-1:0]    packet_vc;
    logic [16*N-1:0]   packet_wc_df;
    logic [N-1:0]      packet_data_valid;
    logic [64*N-1:0]   packet_data;
    logic [N-1:0]      packet_rdy;
    logic [N-1:0]      packet_data_rdy;

    modport master (
        output packet_valid, packet_dt, packet_vc, packet_wc_df,
        output packet_data_valid, packet_data,
        input  packet_rdy, packet_data_rdy
    );

    modport slave (
        input  packet_valid, packet_dt, packet_vc, packet_wc_df,
        input  packet_data_valid, packet_data,
        output packet_rdy, packet_data_rdy
    );

endinterface

`default_nettype wire

// File: rtl/csi2tx_pkt_if_arbiter_rr_pick.sv
// ============================================================================
// Module      : csi2tx_rr_pick
// Description : Combinational round-robin pick starting after last_grant.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module csi2tx_rr_pick #(
    parameter int NUM_SRC = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [IDX_W-1:0]   idx,
    output logic               found
);

    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            if (!found && req[(int'(last_grant) + k) % NUM_SRC]) begin
                found = 1'b1;
                idx   = IDX_W'((int'(last_grant) + k) % NUM_SRC);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/csi2tx_pkt_if_arbiter.sv
// ============================================================================
// Module      : csi2tx_pkt_if_arbiter
// Description : Per-packet round-robin arbiter of packet readers onto one
//               downstream packet interface. Optional CSI2TX_ARB_FRAME_LOCK_EN
//               pins the grant to one source from Frame Start to Frame End.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module csi2tx_pkt_if_arbiter
    import csi2tx_pkt_if_arbiter_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int IDX_W   = 2
) (
    input  logic                      txbyteclkhs,
    input  logic                      txbyteclkhs_rst_n,
    input  logic                      tinit_start_txbyteclk,
    input  logic                      forcetxstopmode,
    csi2tx_pkt_if_arbiter_if.slave    src,
    csi2tx_pkt_if_arbiter_if.master   pkt,
    output logic [IDX_W-1:0]          arb_grant_idx,
    output logic                      arb_busy
);

    localparam logic [IDX_W-1:0] c_LAST_RST = IDX_W'(NUM_SRC - 1);

    logic               w_clr;
    logic [1:0]         r_state, w_state_nxt;
    logic [IDX_W-1:0]   r_grant, w_grant_nxt;
    logic [IDX_W-1:0]   r_last, w_last_nxt;
    logic [15:0]        r_rem, w_rem_nxt;
    logic [NUM_SRC-1:0] w_req;
    logic [IDX_W-1:0]   w_pick_idx;
    logic               w_pick_found;
    int                 w_sel;

    logic               w_hdr_valid;
    logic [5:0]         w_hdr_dt;
    logic [1:0]         w_hdr_vc;
    logic [15:0]        w_hdr_wc;
    logic               w_dat_valid;
    logic [63:0]        w_dat;
    logic               w_hdr_acc;
    logic               w_beat;
    logic [15:0]        w_rem_hdr;
    logic [15:0]        w_rem_dec;

    assign w_clr = ~tinit_start_txbyteclk | forcetxstopmode;
    assign w_sel = int'(r_grant);

    assign w_hdr_valid = src.packet_valid[w_sel];
    assign w_hdr_dt    = src.packet_dt[w_sel*6 +: 6];
    assign w_hdr_vc    = src.packet_vc[w_sel*2 +: 2];
    assign w_hdr_wc    = src.packet_wc_df[w_sel*16 +: 16];
    assign w_dat_valid = src.packet_data_valid[w_sel];
    assign w_dat       = src.packet_data[w_sel*64 +: 64];

    assign w_hdr_acc = (r_state == ARB_HDR)  & w_hdr_valid & pkt.packet_rdy[0];
    assign w_beat    = (r_state == ARB_DATA) & w_dat_valid & pkt.packet_data_rdy[0];
    assign w_rem_hdr = sat_sub(w_hdr_wc, HDR_PAYLOAD_BYTES);
    assign w_rem_dec = sat_sub(r_rem, BEAT_BYTES);

`ifdef CSI2TX_ARB_FRAME_LOCK_EN
    logic             r_lock, w_lock_nxt;
    logic [IDX_W-1:0] r_lock_idx, w_lock_idx_nxt;

    // Inside a frame only the frame owner may compete.
    assign w_req = r_lock ? (src.packet_valid & (NUM_SRC'(1) << r_lock_idx))
                          : src.packet_valid;
`else
    assign w_req = src.packet_valid;
`endif

    csi2tx_rr_pick #(
        .NUM_SRC    (NUM_SRC),
        .IDX_W      (IDX_W)
    ) u_rr_pick (
        .req        (w_req),
        .last_grant (r_last),
        .idx        (w_pick_idx),
        .found      (w_pick_found)
    );

    always_ff @(posedge txbyteclkhs or negedge txbyteclkhs_rst_n) begin
        if (!txbyteclkhs_rst_n) begin
            r_state    <= ARB_IDLE;
            r_grant    <= '0;
            r_last     <= c_LAST_RST;
            r_rem      <= '0;
`ifdef CSI2TX_ARB_FRAME_LOCK_EN
            r_lock     <= 1'b0;
            r_lock_idx <= '0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_grant    <= w_grant_nxt;
            r_last     <= w_last_nxt;
            r_rem      <= w_rem_nxt;
`ifdef CSI2TX_ARB_FRAME_LOCK_EN
            r_lock     <= w_lock_nxt;
            r_lock_idx <= w_lock_idx_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_last_nxt  = r_last;
        w_rem_nxt   = r_rem;
`ifdef CSI2TX_ARB_FRAME_LOCK_EN
        w_lock_nxt     = r_lock;
        w_lock_idx_nxt = r_lock_idx;
`endif
        if (w_clr) begin
            w_state_nxt = ARB_IDLE;
            w_grant_nxt = '0;
            w_last_nxt  = c_LAST_RST;
            w_rem_nxt   = '0;
`ifdef CSI2TX_ARB_FRAME_LOCK_EN
            w_lock_nxt     = 1'b0;
            w_lock_idx_nxt = '0;
`endif
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_pick_found) begin
                        w_grant_nxt = w_pick_idx;
                        w_state_nxt = ARB_HDR;
                    end
                end
                ARB_HDR: begin
                    if (w_hdr_acc) begin
                        w_last_nxt = r_grant;
                        if (w_hdr_dt <= SHORT_DT_MAX) begin
                            w_rem_nxt   = '0;
                            w_state_nxt = ARB_IDLE;
                        end else begin
                            // The header beat already carried the first payload bytes.
                            w_rem_nxt   = w_rem_hdr;
                            w_state_nxt = (w_rem_hdr == 16'd0) ? ARB_IDLE : ARB_DATA;
                        end
`ifdef CSI2TX_ARB_FRAME_LOCK_EN
                        if (w_hdr_dt == DT_FS) begin
                            w_lock_nxt     = 1'b1;
                            w_lock_idx_nxt = r_grant;
                        end else if (w_hdr_dt == DT_FE && r_lock && r_grant == r_lock_idx) begin
                            w_lock_nxt     = 1'b0;
                        end
`endif
                    end
                end
                ARB_DATA: begin
                    if (w_beat) begin
                        w_rem_nxt = w_rem_dec;
                        if (w_rem_dec == 16'd0) w_state_nxt = ARB_IDLE;
                    end
                end
                default: w_state_nxt = ARB_IDLE;
            endcase
        end
    end

    logic [NUM_SRC-1:0] w_src_rdy;
    logic [NUM_SRC-1:0] w_src_data_rdy;
    logic               w_pv;
    logic [5:0]         w_dt;
    logic [1:0]         w_vc;
    logic [15:0]        w_wc;
    logic               w_dv;
    logic [63:0]        w_data;

    // Clear gates outputs in the same cycle so no handshake completes under it.
    always_comb begin
        w_src_rdy      = '0;
        w_src_data_rdy = '0;
        w_pv           = 1'b0;
        w_dt           = '0;
        w_vc           = '0;
        w_wc           = '0;
        w_dv           = 1'b0;
        w_data         = '0;
        if (!w_clr) begin
            case (r_state)
                ARB_HDR: begin
                    w_pv             = w_hdr_valid;
                    w_dt             = w_hdr_dt;
                    w_vc             = w_hdr_vc;
                    w_wc             = w_hdr_wc;
                    w_src_rdy[w_sel] = pkt.packet_rdy[0];
                end
                ARB_DATA: begin
                    w_dt                  = w_hdr_dt;
                    w_vc                  = w_hdr_vc;
                    w_wc                  = w_hdr_wc;
                    w_dv                  = w_dat_valid;
                    w_data                = w_dat;
                    w_src_data_rdy[w_sel] = pkt.packet_data_rdy[0];
                end
                default: ;
            endcase
        end
    end

    assign src.packet_rdy        = w_src_rdy;
    assign src.packet_data_rdy   = w_src_data_rdy;
    assign pkt.packet_valid      = w_pv;
    assign pkt.packet_dt         = w_dt;
    assign pkt.packet_vc         = w_vc;
    assign pkt.packet_wc_df      = w_wc;
    assign pkt.packet_data_valid = w_dv;
    assign pkt.packet_data       = w_data;

    assign arb_grant_idx = w_clr ? '0 : r_grant;
    assign arb_busy      = ~w_clr & (r_state != ARB_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_csi2tx_pkt_if_arbiter.sv
// ============================================================================
// Module      : tb_csi2tx_pkt_if_arbiter
// Description : Directed self-checking bench for csi2tx_pkt_if_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_csi2tx_pkt_if_arbiter;

    logic       txbyteclkhs;
    logic       txbyteclkhs_rst_n;
    logic       tinit_start_txbyteclk;
    logic       forcetxstopmode;
    logic [1:0] arb_grant_idx;
    logic       arb_busy;

    int checks = 0;
    int errors = 0;

    csi2tx_pkt_if_arbiter_if #(.N(4)) src_if ();
    csi2tx_pkt_if_arbiter_if #(.N(1)) pkt_if ();

    csi2tx_pkt_if_arbiter #(
        .NUM_SRC               (4),
        .IDX_W                 (2)
    ) dut (
        .txbyteclkhs           (txbyteclkhs),
        .txbyteclkhs_rst_n     (txbyteclkhs_rst_n),
        .tinit_start_txbyteclk (tinit_start_txbyteclk),
        .forcetxstopmode       (forcetxstopmode),
        .src                   (src_if),
        .pkt                   (pkt_if),
        .arb_grant_idx         (arb_grant_idx),
        .arb_busy              (arb_busy)
    );

    initial txbyteclkhs = 1'b0;
    always #5 txbyteclkhs = ~txbyteclkhs;

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge txbyteclkhs);
        #1;
    endtask

    task automatic set_src(input int i, input logic v, input logic [5:0] dt,
                           input logic [1:0] vc, input logic [15:0] wc);
        src_if.packet_valid[i]          = v;
        src_if.packet_dt[i*6 +: 6]      = dt;
        src_if.packet_vc[i*2 +: 2]      = vc;
        src_if.packet_wc_df[i*16 +: 16] = wc;
    endtask

    task automatic test_reset();
        txbyteclkhs_rst_n     = 1'b0;
        tinit_start_txbyteclk = 1'b1;
        forcetxstopmode       = 1'b0;
        src_if.packet_valid = '0; src_if.packet_dt = '0; src_if.packet_vc = '0;
        src_if.packet_wc_df = '0; src_if.packet_data_valid = '0; src_if.packet_data = '0;
        pkt_if.packet_rdy = 1'b0; pkt_if.packet_data_rdy = 1'b0;
        #12;
        checks++; if (arb_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %0b exp 0", arb_busy); end
        checks++; if (arb_grant_idx !== 2'd0) begin errors++; $display("FAIL rst_grant got %0d exp 0", arb_grant_idx); end
        checks++; if (pkt_if.packet_valid !== 1'b0) begin errors++; $display("FAIL rst_pv got %0b exp 0", pkt_if.packet_valid); end
        checks++; if (src_if.packet_rdy !== 4'b0000) begin errors++; $display("FAIL rst_rdy got %b exp 0000", src_if.packet_rdy); end
        txbyteclkhs_rst_n = 1'b1;
        tick();
    endtask

    task automatic test_short_rr();
        set_src(0, 1'b1, 6'h08, 2'd0, 16'h1111);
        set_src(2, 1'b1, 6'h08, 2'd2, 16'h2222);
        tick();
        checks++; if (pkt_if.packet_valid !== 1'b1) begin errors++; $display("FAIL short_latency got %0b exp 1", pkt_if.packet_valid); end
        checks++; if (arb_grant_idx !== 2'd0) begin errors++; $display("FAIL short_first got %0d exp 0", arb_grant_idx); end
        checks++; if (pkt_if.packet_wc_df !== 16'h1111) begin errors++; $display("FAIL short_wc0 got %h exp 1111", pkt_if.packet_wc_df); end
        checks++; if (src_if.packet_rdy !== 4'b0000) begin errors++; $display("FAIL short_rdy_low got %b exp 0000", src_if.packet_rdy); end
        pkt_if.packet_rdy = 1'b1;
        #1;
        checks++; if (src_if.packet_rdy !== 4'b0001) begin errors++; $display("FAIL short_rdy0 got %b exp 0001", src_if.packet_rdy); end
        tick();
        src_if.packet_valid[0] = 1'b0;
        checks++; if (arb_busy !== 1'b0) begin errors++; $display("FAIL short_idle got %0b exp 0", arb_busy); end
        tick();
        checks++; if (arb_grant_idx !== 2'd2) begin errors++; $display("FAIL short_second got %0d exp 2", arb_grant_idx); end
        checks++; if (pkt_if.packet_vc !== 2'd2 || pkt_if.packet_wc_df !== 16'h2222) begin
            errors++; $display("FAIL short_hdr2 got vc %0d wc %h exp vc 2 wc 2222", pkt_if.packet_vc, pkt_if.packet_wc_df); end
        checks++; if (src_if.packet_rdy !== 4'b0100) begin errors++; $display("FAIL short_rdy2 got %b exp 0100", src_if.packet_rdy); end
        tick();
        src_if.packet_valid[2] = 1'b0;
    endtask

    task automatic test_long_wc20();
        int beats = 0;
        set_src(1, 1'b1, 6'h2B, 2'd1, 16'd20);
        src_if.packet_data_valid[1] = 1'b1;
        src_if.packet_data[64 +: 64] = 64'hA5A5_0000_1111_2222;
        pkt_if.packet_data_rdy = 1'b1;
        tick();
        checks++; if (arb_grant_idx !== 2'd1) begin errors++; $display("FAIL long_grant got %0d exp 1", arb_grant_idx); end
        checks++; if (pkt_if.packet_data_valid !== 1'b0) begin errors++; $display("FAIL long_dv_in_hdr got %0b exp 0", pkt_if.packet_data_valid); end
        set_src(3, 1'b1, 6'h08, 2'd3, 16'h3333);
        tick();
        for (int c = 0; c < 10 && arb_busy; c++) begin
            if (pkt_if.packet_data_valid[0]) beats++;
            checks++; if (src_if.packet_data_rdy !== 4'b0010 || src_if.packet_rdy !== 4'b0000) begin
                errors++; $display("FAIL long_rdys got drdy %b rdy %b exp 0010 0000", src_if.packet_data_rdy, src_if.packet_rdy); end
            checks++; if (pkt_if.packet_data !== 64'hA5A5_0000_1111_2222) begin
                errors++; $display("FAIL long_data got %h exp a5a5000011112222", pkt_if.packet_data); end
            tick();
        end
        checks++; if (beats !== 2) begin errors++; $display("FAIL long_beats got %0d exp 2", beats); end
        checks++; if (arb_busy !== 1'b0) begin errors++; $display("FAIL long_end got %0b exp 0", arb_busy); end
        src_if.packet_valid[1] = 1'b0;
        src_if.packet_data_valid[1] = 1'b0;
        tick();
        checks++; if (arb_grant_idx !== 2'd3 || pkt_if.packet_wc_df !== 16'h3333) begin
            errors++; $display("FAIL long_next got %0d wc %h exp 3 wc 3333", arb_grant_idx, pkt_if.packet_wc_df); end
        tick();
        src_if.packet_valid[3] = 1'b0;
    endtask

    task automatic test_small_long();
        set_src(0, 1'b1, 6'h2B, 2'd0, 16'd3);
        src_if.packet_data_valid[0] = 1'b1;
        tick();
        checks++; if (arb_grant_idx !== 2'd0 || arb_busy !== 1'b1) begin
            errors++; $display("FAIL wc3_grant got %0d busy %0b exp 0 1", arb_grant_idx, arb_busy); end
        tick();
        checks++; if (arb_busy !== 1'b0 || pkt_if.packet_data_valid !== 1'b0) begin
            errors++; $display("FAIL wc3_nodata got busy %0b dv %0b exp 0 0", arb_busy, pkt_if.packet_data_valid); end
        set_src(0, 1'b1, 6'h2B, 2'd0, 16'd0);
        tick();
        checks++; if (arb_grant_idx !== 2'd0 || arb_busy !== 1'b1) begin
            errors++; $display("FAIL wc0_grant got %0d busy %0b exp 0 1", arb_grant_idx, arb_busy); end
        tick();
        checks++; if (arb_busy !== 1'b0 || pkt_if.packet_data_valid !== 1'b0) begin
            errors++; $display("FAIL wc0_nodata got busy %0b dv %0b exp 0 0", arb_busy, pkt_if.packet_data_valid); end
        src_if.packet_valid[0] = 1'b0;
        src_if.packet_data_valid[0] = 1'b0;
    endtask

    task automatic test_data_toggle();
        int  beats = 0;
        logic acc;
        set_src(2, 1'b1, 6'h2B, 2'd2, 16'd40);
        src_if.packet_data_valid[2] = 1'b1;
        src_if.packet_data[128 +: 64] = 64'd0;
        pkt_if.packet_data_rdy = 1'b0;
        tick();
        checks++; if (arb_grant_idx !== 2'd2) begin errors++; $display("FAIL tog_grant got %0d exp 2", arb_grant_idx); end
        tick();
        for (int c = 0; c < 40 && arb_busy; c++) begin
            pkt_if.packet_data_rdy = (c % 2 == 0);
            #1;
            acc = pkt_if.packet_data_valid[0] & pkt_if.packet_data_rdy[0];
            checks++; if (src_if.packet_data_rdy !== (pkt_if.packet_data_rdy[0] ? 4'b0100 : 4'b0000)) begin
                errors++; $display("FAIL tog_drdy got %b cycle %0d", src_if.packet_data_rdy, c); end
            if (acc) begin
                checks++; if (pkt_if.packet_data !== 64'(beats)) begin
                    errors++; $display("FAIL tog_data got %0d exp %0d", pkt_if.packet_data, beats); end
            end
            tick();
            if (acc) begin
                beats++;
                src_if.packet_data[128 +: 64] = 64'(beats);
            end
        end
        checks++; if (beats !== 5) begin errors++; $display("FAIL tog_beats got %0d exp 5", beats); end
        src_if.packet_valid[2] = 1'b0;
        src_if.packet_data_valid[2] = 1'b0;
        pkt_if.packet_data_rdy = 1'b1;
    endtask

    task automatic test_force_stop();
        set_src(1, 1'b1, 6'h2B, 2'd1, 16'd40);
        src_if.packet_data_valid[1] = 1'b1;
        src_if.packet_data[64 +: 64] = 64'h1;
        tick();
        tick();
        tick();
        src_if.packet_data[64 +: 64] = 64'h2;
        forcetxstopmode = 1'b1;
        #1;
        checks++; if (src_if.packet_data_rdy !== 4'b0000 || pkt_if.packet_data_valid !== 1'b0) begin
            errors++; $display("FAIL stop_gate got drdy %b dv %0b exp 0000 0", src_if.packet_data_rdy, pkt_if.packet_data_valid); end
        tick();
        checks++; if (arb_busy !== 1'b0 || arb_grant_idx !== 2'd0 || pkt_if.packet_data !== 64'd0 || pkt_if.packet_valid !== 1'b0) begin
            errors++; $display("FAIL stop_idle got busy %0b grant %0d data %h pv %0b exp 0 0 0 0",
                               arb_busy, arb_grant_idx, pkt_if.packet_data, pkt_if.packet_valid); end
        forcetxstopmode = 1'b0;
        src_if.packet_data_valid[1] = 1'b0;
        for (int i = 0; i < 4; i++) set_src(i, 1'b1, 6'h08, 2'(i), 16'(16'h1000 + i));
        tick();
        checks++; if (arb_grant_idx !== 2'd0 || pkt_if.packet_wc_df !== 16'h1000) begin
            errors++; $display("FAIL stop_rearb got %0d wc %h exp 0 1000", arb_grant_idx, pkt_if.packet_wc_df); end
        tick();
        src_if.packet_valid = '0;
        forcetxstopmode = 1'b1;
        tick();
        forcetxstopmode = 1'b0;
    endtask

`ifdef CSI2TX_ARB_FRAME_LOCK_EN
    task automatic test_frame_lock();
        set_src(0, 1'b1, 6'h00, 2'd0, 16'h0001);
        tick();
        tick();
        set_src(0, 1'b1, 6'h08, 2'd0, 16'h0002);
        set_src(1, 1'b1, 6'h08, 2'd1, 16'h0003);
        tick();
        checks++; if (arb_grant_idx !== 2'd0) begin errors++; $display("FAIL lock_hold got %0d exp 0", arb_grant_idx); end
        tick();
        set_src(0, 1'b1, 6'h01, 2'd0, 16'h0004);
        tick();
        checks++; if (arb_grant_idx !== 2'd0 || pkt_if.packet_dt !== 6'h01) begin
            errors++; $display("FAIL lock_fe got %0d dt %h exp 0 01", arb_grant_idx, pkt_if.packet_dt); end
        tick();
        src_if.packet_valid[0] = 1'b0;
        tick();
        checks++; if (arb_grant_idx !== 2'd1) begin errors++; $display("FAIL lock_release got %0d exp 1", arb_grant_idx); end
        tick();
        src_if.packet_valid = '0;
    endtask
`endif

    initial begin
        test_reset();
        test_short_rr();
        test_long_wc20();
        test_small_long();
        test_data_toggle();
        test_force_stop();
`ifdef CSI2TX_ARB_FRAME_LOCK_EN
        test_frame_lock();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/csi2tx_pkt_if_arbiter.md
Name: csi2tx_pkt_if_arbiter

Overview:
- Round-robin arbiter that shares the single downstream packet interface (header plus 64-bit payload) between NUM_SRC packet-reader instances, one per sensor/virtual-channel FIFO.
- Holds the grant for the whole packet: header beat plus every payload beat.
- Sits between the packet readers and the lane-management/packet builder in the txbyteclkhs domain.

Parameters:
- NUM_SRC, 4, number of requesting packet readers (legal 2..4).
- IDX_W, 2, width of the grant index; must satisfy 2**IDX_W >= NUM_SRC.

Ports:
- txbyteclkhs  in  1  byte clock.
- txbyteclkhs_rst_n  in  1  asynchronous, active-low reset.
- tinit_start_txbyteclk  in  1  0 = link not initialised; synchronous clear.
- forcetxstopmode  in  1  1 = synchronous clear.
- src_packet_valid  in  NUM_SRC  per-source header valid.
- src_packet_dt  in  6*NUM_SRC  per-source data type; source i at [6i+5:6i].
- src_packet_vc  in  2*NUM_SRC  per-source virtual channel.
- src_packet_wc_df  in  16*NUM_SRC  per-source word count / short-packet data field.
- src_packet_data_valid  in  NUM_SRC  per-source payload valid.
- src_packet_data  in  64*NUM_SRC  per-source payload.
- src_packet_rdy  out  NUM_SRC  header ready to the source.
- src_packet_data_rdy  out  NUM_SRC  payload ready to the source.
- packet_valid, packet_dt[5:0], packet_vc[1:0], packet_wc_df[15:0], packet_data_valid, packet_data[63:0]  out  downstream packet interface.
- packet_rdy, packet_data_rdy  in  1 each  downstream ready.
- arb_grant_idx  out  IDX_W  currently granted source.
- arb_busy  out  1  a grant is held.

Behaviour:
- States:
  - IDLE: no grant held.
  - HDR: granted header is presented downstream.
  - DATA: payload beats of a long packet are forwarded.
- IDLE:
  - If any src_packet_valid is 1, pick the first requester searching from (last_grant+1) mod NUM_SRC upward with wrap. Register it as grant_idx; go to HDR.
  - Else stay in IDLE.
  - Latency from src_packet_valid rising to packet_valid is 1 cycle.
- HDR:
  - packet_valid, dt, vc and wc_df are muxed combinationally from grant_idx.
  - src_packet_rdy[grant_idx] = packet_rdy; all other rdy bits are 0.
  - On packet_rdy = 1:
    - Short packet (dt <= 6'h0F): go to IDLE.
    - Long packet: rem_r <= wc - min(wc,4), because the header beat carries the first 4 payload bytes. If rem_r would be 0, go to IDLE; else go to DATA.
  - In both cases last_grant <= grant_idx.
- DATA:
  - packet_data_valid and packet_data come from the granted source.
  - src_packet_data_rdy[grant_idx] = packet_data_rdy; all other data_rdy bits are 0.
  - Each cycle with data_valid & data_rdy: rem_r <= rem_r - min(rem_r,8). When the result is 0, go to IDLE.
  - A source's data_valid outside its own DATA grant is ignored and never forwarded.
- Ungranted sources always see rdy and data_rdy at 0. A source dropping valid before acceptance does not release the grant.
- Arithmetic: rem_r is 16 bits unsigned. Subtraction saturates at 0, so wc = 0xFFFF never wraps.
- Synchronous clear: tinit_start_txbyteclk = 0 or forcetxstopmode = 1 in any state forces:
  - state to IDLE;
  - grant_idx, last_grant (reset value NUM_SRC-1, so source 0 wins first) and rem_r to 0 or their reset values;
  - all outputs to 0.
  - This also applies mid-packet; the next cycle is IDLE.
- Async reset values: every output is 0, state is IDLE, last_grant = NUM_SRC-1.
- When state is IDLE, packet_data, dt, vc and wc_df are driven to 0.
- arb_busy = (state != IDLE).

Optional Feature:
- Macro: CSI2TX_ARB_FRAME_LOCK_EN.
- When defined:
  - Granting a Frame Start short packet (dt 6'h00) sets frame_lock_r and lock_idx.
  - While locked, IDLE grants only lock_idx and ignores all other sources.
  - Completion of a Frame End short packet (dt 6'h01) from lock_idx clears the lock.
  - Synchronous clear also clears the lock.
- When undefined: pure per-packet round-robin, with no lock registers present.

Decomposition:
- Shared package/defines file (csi2tx_defines) holds:
  - state encodings ARB_IDLE = 2'b00, ARB_HDR = 2'b01, ARB_DATA = 2'b10;
  - DT_FS = 6'h00, DT_FE = 6'h01, SHORT_DT_MAX = 6'h0F;
  - HDR_PAYLOAD_BYTES = 4, BEAT_BYTES = 8.
- One natural sub-module: csi2tx_rr_pick. It is combinational: request vector plus last_grant in, next index plus found flag out. It is reusable by other arbiters.

Test Plan:
- Srcs 0 and 2 both hold short packets (dt 0x12 invalid→use 0x08) from reset → grant 0 first, then 2; packet_valid high 1 cycle after request; each rdy pulse seen only by the granted source.
- Src 1 long packet, wc = 20, packet_rdy and data_rdy always 1 → 1 header beat, then exactly 2 data beats (16 bytes), then IDLE; src 3 requesting concurrently is not granted until the packet ends.
- Long packet wc = 3 → header beat only, DATA never entered; wc = 0 → same.
- packet_data_rdy toggled 1/0 during a wc = 40 packet → exactly 5 data beats; rem_r values 36, 28, 20, 12, 4, 0; no beat lost or duplicated.
- forcetxstopmode pulsed during the 2nd data beat → next cycle IDLE with all outputs 0; after release, source 0 wins re-arbitration with all sources requesting.
- With CSI2TX_ARB_FRAME_LOCK_EN: src 0 sends FS, src 1 requests → src 1 blocked until src 0's FE is accepted, then granted.
